// File: rtl/fft8_stage_scheduler_if.sv
// Control bundle between the system/butterfly array and the FFT stage scheduler.
// The scheduler takes the slave side; the system and the butterflies take the master side.
interface fft8_stage_scheduler_if;
    logic        start;
    logic        abort;
    logic        load_rdy;
    logic [3:0]  rdy1;
    logic [3:0]  rdy2;
    logic [3:0]  rdy3;
    logic        load_en;
    logic [2:0]  stage_en;
    logic [1:0]  stage_sel;
    logic [31:0] tw0;
    logic [31:0] tw1;
    logic [31:0] tw2;
    logic [31:0] tw3;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic        err;
    logic [7:0]  latency;

    modport master (
        output start, abort, load_rdy, rdy1, rdy2, rdy3,
        input  load_en, stage_en, stage_sel, tw0, tw1, tw2, tw3,
               busy, done, result_valid, err, latency
    );

    modport slave (
        input  start, abort, load_rdy, rdy1, rdy2, rdy3,
        output load_en, stage_en, stage_sel, tw0, tw1, tw2, tw3,
               busy, done, result_valid, err, latency
    );
endinterface

// File: rtl/fft8_stage_scheduler.sv
// Sequencer for the 8-point radix-2 FFT: load handshake, three butterfly stages,
// per-butterfly twiddles, completion pulse, run latency and a dwell watchdog.
// Every output is a registered decode of the next state, so outputs change on the
// same edge as the state does.
module fft8_stage_scheduler #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic                         clk,
    input  logic                         reset_n,
    fft8_stage_scheduler_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ST1  = 3'd2,
        S_ST2  = 3'd3,
        S_ST3  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // Twiddle constants, {imag, real} in signed Q8.
    localparam logic [31:0] W0 = 32'h0000_0100;
    localparam logic [31:0] W1 = 32'hFF4B_00B5;
    localparam logic [31:0] W2 = 32'hFF00_0000;
    localparam logic [31:0] W3 = 32'hFF4B_FF4B;

    state_t      state_q, state_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [7:0]  run_q, run_d;
    logic [7:0]  latency_q, latency_d;

    logic        load_en_q, load_en_d;
    logic [2:0]  stage_en_q, stage_en_d;
    logic [1:0]  stage_sel_q, stage_sel_d;
    logic [31:0] tw0_q, tw0_d;
    logic [31:0] tw1_q, tw1_d;
    logic [31:0] tw2_q, tw2_d;
    logic [31:0] tw3_q, tw3_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        result_valid_q, result_valid_d;
    logic        err_q, err_d;

    logic        timeout_hit;
    logic        settled;
    logic        state_busy;

    // The watchdog fires on the cycle whose dwell count would reach TIMEOUT;
    // readiness in STk is only trusted once the state has lasted one full cycle.
    assign timeout_hit = (dwell_q == (TIMEOUT - 8'd1));
    assign settled     = (dwell_q != 8'd0);
    assign state_busy  = (state_q == S_LOAD) || (state_q == S_ST1) ||
                         (state_q == S_ST2)  || (state_q == S_ST3);

    // Next-state selection; abort overrides every other request.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (bus.load_rdy)    state_d = S_ST1;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_ST1: begin
                if (settled && (bus.rdy1 == 4'hF)) state_d = S_ST2;
                else if (timeout_hit)              state_d = S_ERR;
            end
            S_ST2: begin
                if (settled && (bus.rdy2 == 4'hF)) state_d = S_ST3;
                else if (timeout_hit)              state_d = S_ERR;
            end
            S_ST3: begin
                if (settled && (bus.rdy3 == 4'hF)) state_d = S_DONE;
                else if (timeout_hit)              state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) state_d = S_IDLE;
    end

    // Dwell, run and latency counters; latency captures the run count on DONE entry.
    always_comb begin
        if (state_d != state_q)      dwell_d = 8'd0;
        else if (dwell_q == 8'hFF)   dwell_d = dwell_q;
        else                         dwell_d = dwell_q + 8'd1;

        run_d = run_q;
        if (state_busy) begin
            if (run_q != 8'hFF) run_d = run_q + 8'd1;
        end else if (state_d == S_LOAD) begin
            run_d = 8'd0;
        end

        latency_d = latency_q;
        if ((state_d == S_DONE) && (state_q != S_DONE)) latency_d = run_d;
    end

    // Output decode from the next state so the registered outputs track the state.
    always_comb begin
        load_en_d      = (state_d == S_LOAD);
        busy_d         = (state_d == S_LOAD) || (state_d == S_ST1) ||
                         (state_d == S_ST2)  || (state_d == S_ST3);
        result_valid_d = (state_d == S_DONE);
        err_d          = (state_d == S_ERR);
        done_d         = (state_d == S_DONE) && (state_q != S_DONE);
        stage_en_d     = 3'b000;
        stage_sel_d    = 2'd0;
        tw0_d          = W0;
        tw1_d          = W0;
        tw2_d          = W0;
        tw3_d          = W0;
        unique case (state_d)
            S_ST1: begin
                stage_en_d  = 3'b001;
                stage_sel_d = 2'd1;
            end
            S_ST2: begin
                stage_en_d  = 3'b011;
                stage_sel_d = 2'd2;
                tw1_d       = W2;
                tw3_d       = W2;
            end
            S_ST3, S_DONE: begin
                stage_en_d  = 3'b111;
                stage_sel_d = 2'd3;
                tw1_d       = W1;
                tw2_d       = W2;
                tw3_d       = W3;
            end
            default: ;
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            dwell_q        <= 8'd0;
            run_q          <= 8'd0;
            latency_q      <= 8'd0;
            load_en_q      <= 1'b0;
            stage_en_q     <= 3'b000;
            stage_sel_q    <= 2'd0;
            tw0_q          <= W0;
            tw1_q          <= W0;
            tw2_q          <= W0;
            tw3_q          <= W0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample pre-edge values, as real flops do.
            state_q        <= state_d;
            dwell_q        <= dwell_d;
            run_q          <= run_d;
            latency_q      <= latency_d;
            load_en_q      <= load_en_d;
            stage_en_q     <= stage_en_d;
            stage_sel_q    <= stage_sel_d;
            tw0_q          <= tw0_d;
            tw1_q          <= tw1_d;
            tw2_q          <= tw2_d;
            tw3_q          <= tw3_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
        end
    end

    assign bus.load_en      = load_en_q;
    assign bus.stage_en     = stage_en_q;
    assign bus.stage_sel    = stage_sel_q;
    assign bus.tw0          = tw0_q;
    assign bus.tw1          = tw1_q;
    assign bus.tw2          = tw2_q;
    assign bus.tw3          = tw3_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result_valid = result_valid_q;
    assign bus.err          = err_q;
    assign bus.latency      = latency_q;

endmodule

// File: tb/tb_fft8_stage_scheduler.sv
// Bench for fft8_stage_scheduler: a full-timeout instance for run sequencing and a
// TIMEOUT=4 instance for the watchdog. Completions are scoreboarded.
module tb_fft8_stage_scheduler;

    localparam logic [31:0] W0 = 32'h0000_0100;
    localparam logic [31:0] W1 = 32'hFF4B_00B5;
    localparam logic [31:0] W2 = 32'hFF00_0000;
    localparam logic [31:0] W3 = 32'hFF4B_FF4B;

    typedef struct {
        int         cyc;
        logic [7:0] lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    fft8_stage_scheduler_if bus_a ();
    fft8_stage_scheduler_if bus_b ();

    fft8_stage_scheduler #(.TIMEOUT(8'd255)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    fft8_stage_scheduler #(.TIMEOUT(8'd4)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tw_exp(input logic [1:0] sel, input int idx);
        logic [31:0] w;
        w = W0;
        if (sel == 2'd2 && (idx % 2) == 1) w = W2;
        if (sel == 2'd3) begin
            case (idx)
                1: w = W1;
                2: w = W2;
                3: w = W3;
                default: w = W0;
            endcase
        end
        return w;
    endfunction

    task automatic check_stage_a(input string tag, input logic [1:0] sel, input logic [2:0] en);
        check({tag, "_sel"}, bus_a.stage_sel, sel);
        check({tag, "_en"},  bus_a.stage_en,  en);
        check({tag, "_tw0"}, bus_a.tw0, tw_exp(sel, 0));
        check({tag, "_tw1"}, bus_a.tw1, tw_exp(sel, 1));
        check({tag, "_tw2"}, bus_a.tw2, tw_exp(sel, 2));
        check({tag, "_tw3"}, bus_a.tw3, tw_exp(sel, 3));
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_load_en"}, bus_a.load_en, 0);
        check({tag, "_busy"},    bus_a.busy, 0);
        check({tag, "_done"},    bus_a.done, 0);
        check({tag, "_rv"},      bus_a.result_valid, 0);
        check({tag, "_err"},     bus_a.err, 0);
        check({tag, "_lat"},     bus_a.latency, 0);
        check_stage_a(tag, 2'd0, 3'b000);
    endtask

    // Scoreboard: every done pulse must match the oldest pending expected completion.
    always @(negedge clk) begin
        if (reset_n && bus_a.done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("done_latency", bus_a.latency, mon_e.lat);
                check("done_rv", bus_a.result_valid, 1);
                check("done_en", bus_a.stage_en, 3'b111);
            end
        end
    end

    initial begin : stim
        int n;
        logic [1:0] sel_min [9] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        logic [2:0] en_min  [9] = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b011,
                                    3'b111, 3'b111, 3'b111, 3'b111};
        logic [1:0] sel;
        logic [2:0] en;

        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.load_rdy = 1'b1;
        bus_a.rdy1 = 4'hF;  bus_a.rdy2 = 4'hF;  bus_a.rdy3 = 4'hF;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.load_rdy = 1'b1;
        bus_b.rdy1 = 4'hF;  bus_b.rdy2 = 4'h7;  bus_b.rdy3 = 4'hF;

        // Reset state.
        repeat (2) tick();
        check_reset_a("reset");
        reset_n = 1'b1;
        tick();
        check_reset_a("idle");

        // Minimal run with all readies high; a start during ST2 must be ignored.
        bus_a.start = 1'b1;
        n = cyc + 1;
        exp_q.push_back('{cyc: n + 7, lat: 8'd7});
        for (int i = 0; i <= 8; i++) begin
            tick();
            if (i == 0) begin
                bus_a.start = 1'b0;
                check("min_load_en", bus_a.load_en, 1);
                check("min_busy", bus_a.busy, 1);
            end
            if (i == 3) bus_a.start = 1'b1;
            if (i == 4) bus_a.start = 1'b0;
            check_stage_a($sformatf("min%0d", i), sel_min[i], en_min[i]);
            if (i == 8) begin
                check("min_done_low", bus_a.done, 0);
                check("min_rv_held", bus_a.result_valid, 1);
                check("min_busy_after", bus_a.busy, 0);
            end
        end
        repeat (2) tick();
        check("rv_level", bus_a.result_valid, 1);

        // Delayed load_rdy and one late rdy2 bit: latency 12.
        bus_a.load_rdy = 1'b0;
        bus_a.rdy2 = 4'hB;
        bus_a.start = 1'b1;
        n = cyc + 1;
        exp_q.push_back('{cyc: n + 12, lat: 8'd12});
        for (int i = 0; i <= 12; i++) begin
            tick();
            if (i == 0) begin
                bus_a.start = 1'b0;
                check("dly_rv_clr", bus_a.result_valid, 0);
            end
            if (i == 3) bus_a.load_rdy = 1'b1;
            if (i == 9) bus_a.rdy2 = 4'hF;
            sel = (i <= 3) ? 2'd0 : (i <= 5) ? 2'd1 : (i <= 9) ? 2'd2 : 2'd3;
            en  = (i <= 3) ? 3'b000 : (i <= 5) ? 3'b001 : (i <= 9) ? 3'b011 : 3'b111;
            check($sformatf("dly%0d", i), bus_a.stage_sel, sel);
            check($sformatf("dly_en%0d", i), bus_a.stage_en, en);
            check($sformatf("dly_ld%0d", i), bus_a.load_en, (i <= 3) ? 1 : 0);
        end
        tick();

        // Abort during ST3: no done, latency keeps 12.
        bus_a.start = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            tick();
            if (i == 0) bus_a.start = 1'b0;
        end
        check("abt_in_st3", bus_a.stage_sel, 2'd3);
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        check("abt_busy", bus_a.busy, 0);
        check("abt_rv", bus_a.result_valid, 0);
        check("abt_lat", bus_a.latency, 8'd12);
        check_stage_a("abt", 2'd0, 3'b000);
        repeat (3) tick();

        // start and abort together stay in IDLE.
        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        check("sa_busy", bus_a.busy, 0);
        check("sa_load_en", bus_a.load_en, 0);

        // Asynchronous reset mid-LOAD.
        bus_a.load_rdy = 1'b0;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("rst_pre_load_en", bus_a.load_en, 1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_a("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        bus_a.load_rdy = 1'b1;
        tick();
        check_reset_a("post_rst");

        // Watchdog on the TIMEOUT=4 instance: rdy2 stuck at 4'h7.
        bus_b.start = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            tick();
            if (i == 0) bus_b.start = 1'b0;
            if (i == 6) begin
                check("to_st2_sel", bus_b.stage_sel, 2'd2);
                check("to_st2_err", bus_b.err, 0);
            end
            if (i == 7) begin
                check("to_err", bus_b.err, 1);
                check("to_en", bus_b.stage_en, 3'b000);
                check("to_busy", bus_b.busy, 0);
                check("to_load_en", bus_b.load_en, 0);
                check("to_sel", bus_b.stage_sel, 2'd0);
                check("to_lat", bus_b.latency, 8'd0);
            end
            if (i == 8) check("to_err_hold", bus_b.err, 1);
        end
        bus_b.rdy2 = 4'hF;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        check("rec_err_clr", bus_b.err, 0);
        check("rec_load_en", bus_b.load_en, 1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("rec_done%0d", i), bus_b.done, (i == 7) ? 1 : 0);
        end
        check("rec_lat", bus_b.latency, 8'd7);
        check("rec_rv", bus_b.result_valid, 1);
        check("rec_tw3", bus_b.tw3, W3);

        repeat (2) tick();
        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
